// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready request into APB SETUP/ACCESS transfers toward two slaves.
// Optional ACCESS-phase timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned SEL_BIT = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_prot,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  PSEL,
  output logic        PENABLE,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [2:0]  PPROT,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        write_q, sel_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  prot_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        accept, done, timeout;

  assign accept = (state_q == IDLE) && req_valid;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] cnt_q;

  // cnt_q holds the number of earlier PREADY-low ACCESS cycles of this transfer.
  assign timeout = (state_q == ACCESS) && !PREADY && (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= 16'd0;
    end else if (state_q == SETUP) begin
      cnt_q <= 16'd0;
    end else if (state_q == ACCESS && !PREADY) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign done = (state_q == ACCESS) && (PREADY || timeout);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      sel_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      prot_q      <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= done;
      if (accept) begin
        write_q <= req_write;
        sel_q   <= req_addr[SEL_BIT];
        addr_q  <= req_addr;
        wdata_q <= req_write ? req_wdata : 32'd0;
        prot_q  <= req_prot;
      end
      if (done) begin
        // A timeout only fires with PREADY low, so PREADY alone tells the two apart.
        rsp_err_q   <= PREADY ? PSLVERR : 1'b1;
        rsp_rdata_q <= (PREADY && !write_q) ? PRDATA : 32'd0;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign PSEL      = (state_q == IDLE) ? 2'b00 : (sel_q ? 2'b10 : 2'b01);
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign PPROT     = prot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized transfers
// checked against a transfer-level model (latency, select, response values).
module tb_apb_master_bridge;

  localparam int unsigned SEL_BIT = 12;
  localparam int unsigned TIMEOUT = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] last_rdata = '0, last_addr = '0;
  logic        last_err = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.SEL_BIT(SEL_BIT), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // One full transfer, starting in a cycle where the bridge is idle. With hold set,
  // req_valid stays high so the caller can present the next request in the response cycle.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] prot, input int waits, input logic [31:0] rdata,
                         input bit slverr, input bit hold);
    logic [1:0]  exp_sel;
    logic [31:0] exp_pwdata, exp_rdata;
    logic        exp_err;
    bit          to;
    int          nacc;
    exp_sel    = addr[SEL_BIT] ? 2'b10 : 2'b01;
    exp_pwdata = wr ? wdata : 32'd0;
    to         = TO_EN && (waits >= int'(TIMEOUT));
    nacc       = to ? int'(TIMEOUT) : waits + 1;
    exp_err    = to ? 1'b1 : slverr;
    exp_rdata  = (to || wr) ? 32'd0 : rdata;

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_prot = prot;
    #1;
    n_checks++;
    if ({req_ready, PSEL, PENABLE} !== {1'b1, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_before_accept: ready/psel/penable=%b required %b",
               {req_ready, PSEL, PENABLE}, {1'b1, 2'b00, 1'b0});
    end
    @(posedge PCLK); #1;
    if (!hold) begin
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = ~wr;
    end
    @(negedge PCLK);
    n_checks++;
    if ({PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWRITE, PWDATA, PPROT} !==
        {exp_sel, 1'b0, 1'b0, 1'b0, addr, wr, exp_pwdata, prot}) begin
      n_fail++;
      $display("FAIL setup_phase: psel=%b pen=%b rdy=%b rv=%b paddr=%h pw=%b pwdata=%h pprot=%h required psel=%b pen=0 rdy=0 rv=0 paddr=%h pw=%b pwdata=%h pprot=%h",
               PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWRITE, PWDATA, PPROT,
               exp_sel, addr, wr, exp_pwdata, prot);
    end
    @(posedge PCLK); #1;
    for (int i = 0; i < nacc; i++) begin
      PREADY  = !to && (i == waits);
      PRDATA  = PREADY ? rdata : $urandom;
      PSLVERR = PREADY ? slverr : 1'b1;
      @(negedge PCLK);
      n_checks++;
      if ({PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWRITE, PWDATA, PPROT} !==
          {exp_sel, 1'b1, 1'b0, 1'b0, addr, wr, exp_pwdata, prot}) begin
        n_fail++;
        $display("FAIL access_phase[%0d]: psel=%b pen=%b rdy=%b rv=%b paddr=%h pw=%b pwdata=%h required psel=%b pen=1 rdy=0 rv=0 paddr=%h pw=%b pwdata=%h",
                 i, PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWRITE, PWDATA,
                 exp_sel, addr, wr, exp_pwdata);
      end
      @(posedge PCLK); #1;
    end
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = $urandom;
    @(negedge PCLK);
    n_checks++;
    if ({rsp_valid, req_ready, PSEL, PENABLE, rsp_err, rsp_rdata} !==
        {1'b1, 1'b1, 2'b00, 1'b0, exp_err, exp_rdata}) begin
      n_fail++;
      $display("FAIL response: rv=%b rdy=%b psel=%b pen=%b err=%b rdata=%h required rv=1 rdy=1 psel=00 pen=0 err=%b rdata=%h",
               rsp_valid, req_ready, PSEL, PENABLE, rsp_err, rsp_rdata, exp_err, exp_rdata);
    end
    last_rdata = exp_rdata; last_err = exp_err; last_addr = addr;
  endtask

  // One idle cycle after a response: pulse must be gone, response and bus fields held.
  task automatic idle_cycle();
    req_valid = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    n_checks++;
    if ({rsp_valid, req_ready, PSEL, PENABLE, rsp_err, rsp_rdata, PADDR} !==
        {1'b0, 1'b1, 2'b00, 1'b0, last_err, last_rdata, last_addr}) begin
      n_fail++;
      $display("FAIL idle_hold: rv=%b rdy=%b psel=%b pen=%b err=%b rdata=%h paddr=%h required rv=0 rdy=1 psel=00 pen=0 err=%b rdata=%h paddr=%h",
               rsp_valid, req_ready, PSEL, PENABLE, rsp_err, rsp_rdata, PADDR,
               last_err, last_rdata, last_addr);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({PSEL, PENABLE, rsp_valid, req_ready, PADDR, PWDATA, PWRITE, PPROT, rsp_rdata, rsp_err}
        !== {2'b00, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: psel=%b pen=%b rv=%b rdy=%b paddr=%h pwdata=%h required all zero, rdy=1",
               PSEL, PENABLE, rsp_valid, req_ready, PADDR, PWDATA);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_write_zero_wait();
    do_xfer(1'b1, 32'h0000_0002, 32'h0000_000F, 3'b000, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_read_waits();
    do_xfer(1'b0, 32'h0000_1003, 32'h1234_5678, 3'b101, 2, 32'h0000_00D7, 1'b0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_slave_error();
    do_xfer(1'b0, 32'h0000_0040, 32'h0, 3'b010, 1, 32'h0000_0055, 1'b1, 1'b0);
    idle_cycle();
    // PSLVERR is driven high during the wait cycles and must be ignored there.
    do_xfer(1'b1, 32'h0000_1040, 32'hA5A5_0001, 3'b001, 3, 32'h0, 1'b0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 32'h0000_1100, 32'h0BAD_F00D, 3'b011, 0, 32'h0, 1'b0, 1'b1);
    do_xfer(1'b0, 32'h0000_0200, 32'h0, 3'b100, 1, 32'hCAFE_0042, 1'b0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_reset_in_access();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_1008; req_wdata = 32'h7777_0000;
    req_prot = 3'b111;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    #3;
    PRESET = 1'b1;
    #1;
    n_checks++;
    if ({PSEL, PENABLE, rsp_valid, req_ready, PADDR, PWDATA} !==
        {2'b00, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_access: psel=%b pen=%b rv=%b rdy=%b paddr=%h pwdata=%h required psel=00 pen=0 rv=0 rdy=1 paddr=0 pwdata=0",
               PSEL, PENABLE, rsp_valid, req_ready, PADDR, PWDATA);
    end
    PREADY = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, PSEL} !== {1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL ready_after_release: rdy=%b psel=%b required rdy=1 psel=00",
               req_ready, PSEL);
    end
    @(posedge PCLK); #1;
    @(negedge PCLK);
    n_checks++;
    if ({rsp_valid, req_ready, PENABLE} !== {1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL no_rsp_after_abort: rv=%b rdy=%b pen=%b required rv=0 rdy=1 pen=0",
               rsp_valid, req_ready, PENABLE);
    end
    PREADY = 1'b0;
    last_rdata = 32'd0; last_err = 1'b0; last_addr = 32'd0;
  endtask

  task automatic test_timeout();
    // Timeout build: errors out after 4 ACCESS cycles. Otherwise waits 100 cycles for PREADY.
    do_xfer(1'b0, 32'h0000_1ABC, 32'h0, 3'b000, 100, 32'h1357_9BDF, 1'b0, 1'b0);
    idle_cycle();
    // PREADY in the 4th ACCESS cycle wins over a coincident timeout.
    do_xfer(1'b0, 32'h0000_0ABC, 32'h0, 3'b000, int'(TIMEOUT) - 1, 32'h2468_ACE0, 1'b1, 1'b0);
    idle_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit hold;
      hold = (i != 23) && ($urandom_range(0, 1) == 1);
      do_xfer(1'($urandom), 32'($urandom), 32'($urandom), 3'($urandom),
              int'($urandom_range(0, 3)), 32'($urandom), 1'($urandom), hold);
      if (!hold) idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slave_error();
    test_back_to_back();
    test_reset_in_access();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that converts a simple valid/ready request port into APB SETUP/ACCESS transfers toward up to two peripheral slaves, such as the GPIO APB block. It sits between the core-side bus fabric and the APB peripherals. It drives PSEL/PENABLE/PADDR/PWRITE/PWDATA/PPROT, waits on PREADY, and returns PRDATA/PSLVERR as a one-cycle response pulse.

## Interface
- SEL_BIT, 12, address bit that selects the slave: 0 selects PSEL[0], 1 selects PSEL[1].
- TIMEOUT, 16, ACCESS-phase cycle limit. Only used when APB_MASTER_TIMEOUT_EN is defined.
- PCLK  in  1  single clock; all logic is on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_prot  in  3  value driven on PPROT.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR, or timeout.
- PSEL  out  2  one-hot slave select.
- PENABLE  out  1  ACCESS phase.
- PADDR  out  32  address.
- PWRITE  out  1  direction.
- PWDATA  out  32  write data; 0 during reads.
- PPROT  out  3  protection.
- PRDATA  in  32  slave read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

## Operation
- FSM states and transitions:
  - IDLE → SETUP when req_valid is high at a clock edge.
  - SETUP → ACCESS unconditionally.
  - ACCESS → IDLE when PREADY is high, or on timeout.
  - ACCESS → ACCESS otherwise.
- req_ready = 1 only in IDLE. It is combinational from the state register and never depends on req_valid.
- On acceptance, capture req_write/req_addr/req_wdata/req_prot into registers that drive PWRITE/PADDR/PWDATA/PPROT.
  - PWDATA is loaded with 0 for reads.
  - These outputs stay stable from SETUP through the end of ACCESS.
  - In IDLE they hold their last values.
- PSEL bit req_addr[SEL_BIT] is high in SETUP and ACCESS, and 0 in IDLE.
- PENABLE is high only in ACCESS.
- Completion: on the edge where state is ACCESS and PREADY is high:
  - rsp_rdata ← PRDATA for reads, 0 for writes.
  - rsp_err ← PSLVERR.
  - rsp_valid = 1 for exactly one cycle.
  - rsp_rdata and rsp_err hold their values until the next completion.
- PRDATA and PSLVERR are ignored whenever PREADY is low, and outside ACCESS.
- There is no response backpressure; the consumer must sample on rsp_valid.
- A request arriving while not in IDLE is not accepted. The requester holds it until req_ready is high.
- Reset (asynchronous, at any point, including mid-transfer):
  - State → IDLE.
  - All outputs → 0, except req_ready → 1.
  - No response is produced for the aborted transfer.

## Timing
- Acceptance edge at cycle T:
  - SETUP is visible in cycle T+1.
  - ACCESS in T+2.
- If PREADY is high in T+2, rsp_valid is high in T+3 and state is IDLE in T+3.
  - The next request can be accepted at the end of T+3.
  - Minimum 3 cycles per transfer.
- Each wait state (PREADY low in ACCESS) adds one cycle.
- rsp_valid coincides with req_ready = 1.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments every ACCESS cycle with PREADY low.
  - When PREADY is still low in the TIMEOUT-th ACCESS cycle, that edge completes the transfer: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, state → IDLE.
  - If PREADY and the timeout occur on the same edge, PREADY wins (normal completion).
- APB_MASTER_TIMEOUT_EN undefined:
  - No counter; ACCESS waits indefinitely for PREADY.
  - The TIMEOUT parameter is unused.

## Test plan
- Write, zero wait states.
  - Stimulus: req addr 0x0000_0002, wdata 0x0000_000F, write = 1, PREADY tied high.
  - Required: PSEL = 01 in T+1 and T+2, PENABLE high only in T+2, PWDATA = 0x0F; rsp_valid in T+3 with rsp_err = 0 and rsp_rdata = 0.
- Read to slave 1 with 2 wait states.
  - Stimulus: addr 0x0000_1003, PRDATA = 0x0000_00D7, PREADY low for 2 ACCESS cycles.
  - Required: PSEL = 10, PWDATA = 0, PADDR stable throughout; rsp_rdata = 0xD7 in T+5.
- Slave error.
  - Stimulus: PSLVERR = 1 together with PREADY.
  - Required: rsp_err = 1. A PSLVERR pulse during a PREADY-low cycle is ignored.
- Back-to-back requests.
  - Stimulus: req_valid held high for two requests.
  - Required: req_ready low in SETUP and ACCESS; the second acceptance happens in the rsp_valid cycle; no APB phase is skipped.
- Reset in ACCESS.
  - Stimulus: PRESET asserted asynchronously mid-clock.
  - Required: PSEL = 00, PENABLE = 0, rsp_valid = 0 immediately; req_ready = 1 after release.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT = 4.
  - Stimulus: PREADY held low.
  - Required: rsp_valid with rsp_err = 1 and rsp_rdata = 0 after 4 ACCESS cycles. Without the macro, the bridge is still in ACCESS after 100 cycles.
